// File: rtl/context_slot_manager.sv
// rtl/context_slot_manager.sv - thread context slot table with work-queue dispatch and trigger wake-up
//
// Purpose: tracks NUM_SLOTS thread contexts (status + id), executes slot
// commands (ALLOC/DELETE/SLEEP/FORK/TEMPLATE), wakes waiting slots by id and
// dispatches runnable slots in FIFO order through the issue handshake.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (blocked while a trigger is offered)
//   cmd_op, cmd_slot, cmd_id,     command opcode, target/source slot, thread id,
//   cmd_fork_sleep                fork child parks in wait_for_trigger
//   rsp_valid, rsp_slot, rsp_err  one-cycle result of an accepted command
//   trig_valid/trig_ready, trig_id   wake-up trigger handshake and id
//   trig_miss                     pulse: accepted trigger matched no waiting slot
//   issue_valid/issue_ready,      work queue head dispatch handshake,
//   issue_slot, issue_id          head slot and its id
//   slot_status                   3-bit status per slot, slot 0 in [2:0]
//   free_count                    number of no_thread slots
module context_slot_manager #(
    parameter int NUM_SLOTS = 8,
    parameter int ID_W      = 8,
    localparam int SW       = $clog2(NUM_SLOTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [SW-1:0]          cmd_slot,
    input  logic [ID_W-1:0]        cmd_id,
    input  logic                   cmd_fork_sleep,
    output logic                   rsp_valid,
    output logic [SW-1:0]          rsp_slot,
    output logic                   rsp_err,
    input  logic                   trig_valid,
    output logic                   trig_ready,
    input  logic [ID_W-1:0]        trig_id,
    output logic                   trig_miss,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [SW-1:0]          issue_slot,
    output logic [ID_W-1:0]        issue_id,
    output logic [3*NUM_SLOTS-1:0] slot_status,
    output logic [SW:0]            free_count
);

    localparam logic [2:0] ST_NONE = 3'd0;
    localparam logic [2:0] ST_EXEC = 3'd1;
    localparam logic [2:0] ST_TMPL = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_WQ   = 3'd4;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_ALLOC  = 3'd1;
    localparam logic [2:0] OP_DELETE = 3'd2;
    localparam logic [2:0] OP_SLEEP  = 3'd3;
    localparam logic [2:0] OP_FORK   = 3'd4;
    localparam logic [2:0] OP_TMPL   = 3'd5;

    logic [2:0]      st    [NUM_SLOTS];
    logic [ID_W-1:0] ids   [NUM_SLOTS];
    logic [SW-1:0]   q_mem [NUM_SLOTS];
    // Extra MSB on each pointer separates full from empty.
    logic [SW:0]     wr_ptr;
    logic [SW:0]     rd_ptr;

    logic            cmd_fire;
    logic            trig_fire;
    logic            pop;
    logic            free_found;
    logic [SW-1:0]   free_idx;
    logic            wait_found;
    logic [SW-1:0]   wait_idx;
    logic [2:0]      cur_st;

    // Single status write port shared by command and trigger: they are
    // mutually exclusive because cmd_ready drops whenever a trigger is offered.
    logic            upd_en;
    logic [SW-1:0]   upd_slot;
    logic [2:0]      upd_st;
    logic            upd_alloc;
    logic            upd_freed;
    logic            push_en;
    logic            r_err;
    logic [SW-1:0]   r_slot;

    assign trig_ready  = !rst;
    assign cmd_ready   = !rst && !trig_valid;
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign trig_fire   = trig_valid && trig_ready;
    assign issue_valid = (wr_ptr != rd_ptr);
    assign issue_slot  = issue_valid ? q_mem[rd_ptr[SW-1:0]] : '0;
    assign issue_id    = issue_valid ? ids[issue_slot] : '0;
    assign pop         = issue_valid && issue_ready;
    assign cur_st      = st[cmd_slot];

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_status
        assign slot_status[3*g +: 3] = st[g];
    end

    // Lowest-index searches: scanning downward lets the lowest hit win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        wait_found = 1'b0;
        wait_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (st[i] == ST_NONE) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
            if (st[i] == ST_WAIT && ids[i] == trig_id) begin
                wait_found = 1'b1;
                wait_idx   = SW'(i);
            end
        end
    end

    always_comb begin
        upd_en    = 1'b0;
        upd_slot  = cmd_slot;
        upd_st    = ST_NONE;
        upd_alloc = 1'b0;
        upd_freed = 1'b0;
        push_en   = 1'b0;
        r_err     = 1'b0;
        r_slot    = cmd_slot;
        if (trig_fire) begin
            if (wait_found) begin
                upd_en   = 1'b1;
                upd_slot = wait_idx;
                upd_st   = ST_WQ;
                push_en  = 1'b1;
            end
        end else if (cmd_fire) begin
            case (cmd_op)
                OP_NOP: r_err = 1'b0;
                OP_ALLOC: begin
                    if (free_found) begin
                        upd_en    = 1'b1;
                        upd_slot  = free_idx;
                        upd_st    = ST_WQ;
                        upd_alloc = 1'b1;
                        push_en   = 1'b1;
                        r_slot    = free_idx;
                    end else begin
                        r_err = 1'b1;
                    end
                end
                OP_DELETE: begin
                    if (cur_st == ST_EXEC || cur_st == ST_TMPL || cur_st == ST_WAIT) begin
                        upd_en    = 1'b1;
                        upd_st    = ST_NONE;
                        upd_freed = 1'b1;
                    end else begin
                        r_err = 1'b1;
                    end
                end
                OP_SLEEP: begin
                    if (cur_st == ST_EXEC) begin
                        upd_en = 1'b1;
                        upd_st = ST_WAIT;
                    end else begin
                        r_err = 1'b1;
                    end
                end
                OP_TMPL: begin
                    if (cur_st == ST_EXEC) begin
                        upd_en = 1'b1;
                        upd_st = ST_TMPL;
                    end else begin
                        r_err = 1'b1;
                    end
                end
                OP_FORK: begin
                    if ((cur_st == ST_EXEC || cur_st == ST_TMPL) && free_found) begin
                        upd_en    = 1'b1;
                        upd_slot  = free_idx;
                        upd_st    = cmd_fork_sleep ? ST_WAIT : ST_WQ;
                        upd_alloc = 1'b1;
                        push_en   = !cmd_fork_sleep;
                        r_slot    = free_idx;
                    end else begin
                        r_err = 1'b1;
                    end
                end
                default: r_err = 1'b1;
            endcase
        end
    end

    // The popped head is in work_queue, so no command or trigger in the same
    // cycle can target it; the two status writes never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                st[i]    <= ST_NONE;
                ids[i]   <= '0;
                q_mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            free_count <= (SW+1)'(NUM_SLOTS);
            rsp_valid  <= 1'b0;
            rsp_slot   <= '0;
            rsp_err    <= 1'b0;
            trig_miss  <= 1'b0;
        end else begin
            rsp_valid <= cmd_fire;
            rsp_err   <= cmd_fire && r_err;
            rsp_slot  <= r_slot;
            trig_miss <= trig_fire && !wait_found;
            if (upd_en) begin
                st[upd_slot] <= upd_st;
            end
            if (upd_alloc) begin
                ids[upd_slot] <= cmd_id;
            end
            if (pop) begin
                st[issue_slot] <= ST_EXEC;
                rd_ptr         <= rd_ptr + 1'b1;
            end
            if (push_en) begin
                q_mem[wr_ptr[SW-1:0]] <= upd_slot;
                wr_ptr                <= wr_ptr + 1'b1;
            end
            free_count <= free_count - (SW+1)'(upd_alloc) + (SW+1)'(upd_freed);
        end
    end

endmodule
